// File: rtl/arb_leaf_client.sv
// Leaf-port client for the tree arbiter: queues hold-length jobs and runs the
// four-phase req/ack handshake, holding the lock for each job's length.
module arb_leaf_client #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid,
  input  logic [LEN_W-1:0]       job_len,
  output logic                   job_ready,
  output logic                   req,
  input  logic                   ack,
  output logic                   lock,
  output logic                   done,
  output logic [$clog2(DEPTH):0] pend_cnt,
  output logic                   timeout_flag,
  output logic                   proto_err,
  input  logic                   clr_flags
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOCK, S_RELEASE} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0]  hold_q, hold_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              perr_q, perr_d;
  logic              tmo_set, perr_set;
  logic              push, pop;
  logic [LEN_W-1:0]  head_len;

  assign job_ready    = (cnt_q != FULL);
  assign push         = job_valid && job_ready;
  assign pop          = (state_q == S_REQ) && ack;
  assign head_len     = mem[rd_ptr_q];

  // Outputs decode registered state only, so ack never reaches req combinationally.
  assign req          = (state_q == S_REQ) || (state_q == S_LOCK);
  assign lock         = (state_q == S_LOCK);
  assign done         = done_q;
  assign pend_cnt     = cnt_q;
  assign timeout_flag = tmo_q;
  assign proto_err    = perr_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= job_len;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    wait_d   = wait_q;
    done_d   = 1'b0;
    tmo_set  = 1'b0;
    perr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ack)                 perr_set = 1'b1;
        else if (cnt_q != '0)    state_d  = S_REQ;
      end
      S_REQ: begin
        if (ack) begin
          state_d = S_LOCK;
          hold_d  = (head_len == '0) ? LEN_W'(1) : head_len;
          wait_d  = '0;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + WW'(1);
          if (wait_q == WAIT_MAX - WW'(1)) tmo_set = 1'b1;
        end
      end
      S_LOCK: begin
        hold_d = hold_q - LEN_W'(1);
        if (hold_q == LEN_W'(1)) begin
          state_d = S_RELEASE;
          done_d  = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A flag set in the same cycle as clr_flags takes precedence.
    tmo_d  = tmo_set  || (tmo_q  && !clr_flags);
    perr_d = perr_set || (perr_q && !clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      wait_q   <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      perr_q   <= perr_d;
    end
  end

endmodule

// File: tb/tb_arb_leaf_client.sv
// Directed bench for arb_leaf_client (DEPTH=4, LEN_W=4, TIMEOUT=64).
module tb_arb_leaf_client;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       job_valid;
  logic [3:0] job_len;
  logic       job_ready;
  logic       req;
  logic       ack;
  logic       lock;
  logic       done;
  logic [2:0] pend_cnt;
  logic       timeout_flag;
  logic       proto_err;
  logic       clr_flags;

  int vectors = 0;
  int miscmp  = 0;
  bit auto_ack = 1'b0;

  arb_leaf_client #(.DEPTH(4), .LEN_W(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_len(job_len),
    .job_ready(job_ready), .req(req), .ack(ack), .lock(lock), .done(done),
    .pend_cnt(pend_cnt), .timeout_flag(timeout_flag), .proto_err(proto_err),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // In auto mode ack follows req with one cycle of delay, like an arbiter cell.
  task automatic tick();
    logic prev;
    prev = req;
    @(posedge clk);
    #1;
    if (auto_ack) ack = prev;
  endtask

  task automatic push(input logic [3:0] len);
    job_valid = 1'b1;
    job_len   = len;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_lock(input int exp_len, input string tag);
    int n;
    int b;
    b = 0;
    while (!lock && b < 100) begin tick(); b++; end
    chk({tag, "_seen"}, 32'(lock), 32'd1);
    n = 0;
    while (lock && n < 40) begin n++; tick(); end
    chk({tag, "_len"}, 32'(n), 32'(exp_len));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_reqlow"}, 32'(req), 32'd0);
    tick();
    chk({tag, "_done1"}, 32'(done), 32'd0);
  endtask

  initial begin
    int nlocks;
    rst_n = 1'b0; job_valid = 1'b0; job_len = '0; ack = 1'b0; clr_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pend", 32'(pend_cnt), 32'd0);
    chk("rst_ready", 32'(job_ready), 32'd1);
    chk("rst_tmo", 32'(timeout_flag), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("idle_req", 32'(req), 32'd0);

    // Single job of length 3
    auto_ack = 1'b1;
    push(4'd3);
    chk("t1_pend1", 32'(pend_cnt), 32'd1);
    chk("t1_req_e0", 32'(req), 32'd0);
    tick();
    chk("t1_req_e1", 32'(req), 32'd1);
    wait_lock(3, "t1");
    chk("t1_pend0", 32'(pend_cnt), 32'd0);

    // Zero length behaves as one
    push(4'd0);
    wait_lock(1, "t2");

    // FIFO full with ack held low
    auto_ack = 1'b0; ack = 1'b0;
    tick(); tick();
    push(4'd2); push(4'd5); push(4'd1); push(4'd3);
    chk("t3_ready4", 32'(job_ready), 32'd0);
    push(4'd7);
    chk("t3_pend4", 32'(pend_cnt), 32'd4);
    chk("t3_ready", 32'(job_ready), 32'd0);
    chk("t3_req", 32'(req), 32'd1);
    auto_ack = 1'b1;
    wait_lock(2, "t3a");
    wait_lock(5, "t3b");
    wait_lock(1, "t3c");
    wait_lock(3, "t3d");
    nlocks = 0;
    repeat (10) begin tick(); if (lock) nlocks++; end
    chk("t3_nomore", 32'(nlocks), 32'd0);
    chk("t3_pend0", 32'(pend_cnt), 32'd0);

    // Grant timeout
    auto_ack = 1'b0; ack = 1'b0;
    push(4'd2);
    tick();
    chk("t4_req", 32'(req), 32'd1);
    repeat (63) tick();
    chk("t4_tmo63", 32'(timeout_flag), 32'd0);
    tick();
    chk("t4_tmo64", 32'(timeout_flag), 32'd1);
    chk("t4_req64", 32'(req), 32'd1);
    repeat (5) tick();
    chk("t4_req70", 32'(req), 32'd1);
    chk("t4_tmo70", 32'(timeout_flag), 32'd1);
    auto_ack = 1'b1;
    wait_lock(2, "t4");
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("t4_clr", 32'(timeout_flag), 32'd0);

    // Slow ack release with a job pending
    auto_ack = 1'b0; ack = 1'b0;
    tick();
    push(4'd1);
    push(4'd2);
    chk("t5_req", 32'(req), 32'd1);
    ack = 1'b1;
    tick();
    chk("t5_lock", 32'(lock), 32'd1);
    chk("t5_pend", 32'(pend_cnt), 32'd1);
    tick();
    chk("t5_rel_req", 32'(req), 32'd0);
    chk("t5_rel_done", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_req", 32'(req), 32'd0);
      chk("t5_hold_lock", 32'(lock), 32'd0);
    end
    chk("t5_hold_done", 32'(done), 32'd0);
    ack = 1'b0;
    tick();
    chk("t5_gap_req", 32'(req), 32'd0);
    tick();
    chk("t5_resume", 32'(req), 32'd1);
    auto_ack = 1'b1;
    wait_lock(2, "t5");
    chk("t5_perr", 32'(proto_err), 32'd0);

    // Reset mid-lock, then a spurious ack in IDLE
    push(4'd7);
    push(4'd7);
    begin
      int b;
      b = 0;
      while (!lock && b < 20) begin tick(); b++; end
    end
    chk("t6_inlock", 32'(lock), 32'd1);
    chk("t6_pend", 32'(pend_cnt), 32'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", 32'(req), 32'd0);
    chk("t6_lock", 32'(lock), 32'd0);
    chk("t6_pend0", 32'(pend_cnt), 32'd0);
    chk("t6_ready", 32'(job_ready), 32'd1);
    auto_ack = 1'b0; ack = 1'b0;
    #2 rst_n = 1'b1;
    tick(); tick();
    chk("t6_idle", 32'(req), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t6_perr", 32'(proto_err), 32'd1);
    chk("t6_perr_req", 32'(req), 32'd0);
    chk("t6_perr_lock", 32'(lock), 32'd0);
    tick();
    chk("t6_still_idle", 32'(req), 32'd0);
    chk("t6_perr_sticky", 32'(proto_err), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("t6_perr_clr", 32'(proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
